// File: rtl/shift_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shift_arbiter_pkg
//   Shared definitions for the shift arbiter slice: widths, op and source
//   encodings, output-stage state type and the two barrel shifters.
// ---------------------------------------------------------------------------
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Logical left barrel shifter: one stage per shift-amount bit, zero fill.
    function automatic logic [DATA_W-1:0] shift_sll(
        input logic [DATA_W-1:0]  din,
        input logic [SHAMT_W-1:0] shamt
    );
        logic [DATA_W-1:0] r;
        r = din;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) r = r << (1 << i);
        end
        return r;
    endfunction

    // Arithmetic right barrel shifter: each stage replicates the sign bit.
    function automatic logic [DATA_W-1:0] shift_sra(
        input logic [DATA_W-1:0]  din,
        input logic [SHAMT_W-1:0] shamt
    );
        logic [DATA_W-1:0] r;
        r = din;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) r = $unsigned($signed(r) >>> (1 << i));
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_rr_arb.sv
// ---------------------------------------------------------------------------
// shift_rr_arb
//   Two-port round-robin arbiter for the shared shifter.
//   Ports:
//     a_valid, b_valid   in   requests from port A / port B
//     last_grant         in   source of the last accepted request
//     free               in   output stage can load this cycle
//     grant_a, grant_b   out  arbitration winner (independent of free)
//     a_ready, b_ready   out  grant qualified by free
// ---------------------------------------------------------------------------
module shift_rr_arb
    import shift_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_grant,
    input  logic free,
    output logic grant_a,
    output logic grant_b,
    output logic a_ready,
    output logic b_ready
);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            // Tie: whoever did not win last time goes now.
            if (last_grant == SRC_A) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    assign a_ready = grant_a & free;
    assign b_ready = grant_b & free;

endmodule

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//   Shares one sll/sra barrel shifter pair between two requesters (A = ALU
//   shift path, B = multdiv/immediate-adjust path) with round-robin
//   arbitration and a single-entry registered output stage (1-cycle latency,
//   1 shift per cycle, same-cycle drain and accept).
//
//   Optional build macro: SHIFT_GRANT_CNT_EN adds saturating 16-bit
//   handshake counters a_grant_cnt / b_grant_cnt.
//
//   Ports:
//     clock                      in   system clock, rising edge
//     reset                      in   asynchronous active-low reset
//     a_valid/a_ready            in/out  port A handshake
//     a_data, a_shamt, a_op      in   port A operand, amount, op (0 sll, 1 sra)
//     b_*                        same as port A for port B
//     out_valid/out_ready        out/in  result handshake
//     out_data                   out  shifted result
//     out_src                    out  result origin (0 = A, 1 = B)
//     a_grant_cnt, b_grant_cnt   out  handshake counters (SHIFT_GRANT_CNT_EN)
//     busy                       out  same as out_valid
//
//   Output stage states:
//     state    | meaning
//     ST_EMPTY | no result held, out_valid = 0
//     ST_FULL  | result held in out_data/out_src, out_valid = 1
// ---------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int SW = SHAMT_W
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] a_data,
    input  logic [SW-1:0] a_shamt,
    input  logic          a_op,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic [DW-1:0] b_data,
    input  logic [SW-1:0] b_shamt,
    input  logic          b_op,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_src,
`ifdef SHIFT_GRANT_CNT_EN
    output logic [15:0]   a_grant_cnt,
    output logic [15:0]   b_grant_cnt,
`endif
    output logic          busy
);

    out_state_e    state_q;
    out_state_e    state_d;
    logic          last_grant;
    logic          free;
    logic          grant_a;
    logic          grant_b;
    logic          acc_a;
    logic          acc_b;
    logic          accept;
    logic          drain;
    logic [DW-1:0] sel_data;
    logic [SW-1:0] sel_shamt;
    logic          sel_op;
    logic [DW-1:0] sll_res;
    logic [DW-1:0] sra_res;
    logic [DW-1:0] shift_res;

    assign out_valid = (state_q == ST_FULL);
    assign busy      = out_valid;
    assign free      = !out_valid | out_ready;

    shift_rr_arb u_arb (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .last_grant (last_grant),
        .free       (free),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .a_ready    (a_ready),
        .b_ready    (b_ready)
    );

    assign acc_a  = a_valid & a_ready;
    assign acc_b  = b_valid & b_ready;
    assign accept = acc_a | acc_b;
    assign drain  = out_valid & out_ready;

    // Operand steering follows the grant so only one shifter pair is needed.
    assign sel_data  = grant_b ? b_data  : a_data;
    assign sel_shamt = grant_b ? b_shamt : a_shamt;
    assign sel_op    = grant_b ? b_op    : a_op;

    assign sll_res   = shift_sll(sel_data, sel_shamt);
    assign sra_res   = shift_sra(sel_data, sel_shamt);
    assign shift_res = (sel_op == SHIFT_OP_SRA) ? sra_res : sll_res;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept)           state_d = ST_FULL;
            ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
            default:                        state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result and arbitration history only move on an accepted request, so a
    // pure drain leaves out_data/out_src holding the last result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_src    <= SRC_A;
            last_grant <= SRC_B;
        end else if (accept) begin
            out_data   <= shift_res;
            out_src    <= acc_b ? SRC_B : SRC_A;
            last_grant <= acc_b ? SRC_B : SRC_A;
        end
    end

`ifdef SHIFT_GRANT_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (acc_a && (a_grant_cnt != 16'hFFFF)) a_grant_cnt <= a_grant_cnt + 16'd1;
            if (acc_b && (b_grant_cnt != 16'hFFFF)) b_grant_cnt <= b_grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clock;
    logic        reset;
    logic        a_valid, a_ready, a_op;
    logic [31:0] a_data;
    logic [4:0]  a_shamt;
    logic        b_valid, b_ready, b_op;
    logic [31:0] b_data;
    logic [4:0]  b_shamt;
    logic        out_valid, out_ready, out_src, busy;
    logic [31:0] out_data;
`ifdef SHIFT_GRANT_CNT_EN
    logic [15:0] a_grant_cnt, b_grant_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        src;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .a_shamt    (a_shamt),
        .a_op       (a_op),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_data     (b_data),
        .b_shamt    (b_shamt),
        .b_op       (b_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
`ifdef SHIFT_GRANT_CNT_EN
        .a_grant_cnt(a_grant_cnt),
        .b_grant_cnt(b_grant_cnt),
`endif
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every output transfer is compared with the oldest expectation.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected got src=%0d data=%h required no transfer", out_src, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_src !== e.src || out_data !== e.data) begin
                    n_err++;
                    $display("FAIL out_result got src=%0d data=%h required src=%0d data=%h",
                             out_src, out_data, e.src, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s got %h required %h", name, got, expv);
        end
    endtask

    task automatic chk_rdy(input string name, input logic ea, input logic eb);
        #1;
        chk({name, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        chk({name, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    endtask

    task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
        a_valid = v; a_data = d; a_shamt = s; a_op = op;
    endtask

    task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
        b_valid = v; b_data = d; b_shamt = s; b_op = op;
    endtask

    task automatic push(input logic src, input logic [31:0] d);
        exp_t e;
        e.src  = src;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b0;
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        step(); step();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", {31'd0, out_src}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        chk_rdy("idle", 1'b0, 1'b0);
        step();

        // 1: A only, sra by 4 of the sign bit
        out_ready = 1'b1;
        set_a(1'b1, 32'h8000_0000, 5'd4, 1'b1);
        push(1'b0, 32'hF800_0000);
        chk_rdy("t1", 1'b1, 1'b0);
        step();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);

        // 2: B only, sll 31 and shamt 0 pass-through
        set_b(1'b1, 32'h0000_0001, 5'd31, 1'b0);
        push(1'b1, 32'h8000_0000);
        chk_rdy("t2a", 1'b0, 1'b1);
        step();
        set_b(1'b1, 32'h1234_5678, 5'd0, 1'b0);
        push(1'b1, 32'h1234_5678);
        chk_rdy("t2b", 1'b0, 1'b1);
        step();

        // 3: both requesting, alternating grants with no bubbles
        set_a(1'b1, 32'h0000_00F0, 5'd4, 1'b0);
        set_b(1'b1, 32'hFFFF_0000, 5'd8, 1'b1);
        push(1'b0, 32'h0000_0F00);
        chk_rdy("t3c1", 1'b1, 1'b0);
        step();
        set_a(1'b1, 32'h0000_0001, 5'd0, 1'b0);
        push(1'b1, 32'hFFFF_FF00);
        chk_rdy("t3c2", 1'b0, 1'b1);
        step();
        set_b(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b1);
        push(1'b0, 32'h0000_0001);
        chk_rdy("t3c3", 1'b1, 1'b0);
        step();
        set_a(1'b1, 32'h8000_0001, 5'd31, 1'b1);
        push(1'b1, 32'h0000_0000);
        chk_rdy("t3c4", 1'b0, 1'b1);
        step();
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        push(1'b0, 32'hFFFF_FFFF);
        chk_rdy("t3c5", 1'b1, 1'b0);
        step();

        // 4: backpressure with both requesting, then drain + accept together
        out_ready = 1'b0;
        set_a(1'b1, 32'h8000_0000, 5'd0, 1'b1);
        set_b(1'b1, 32'h0000_FFFF, 5'd16, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("t4stall", 1'b0, 1'b0);
            chk("t4_hold_data", out_data, 32'hFFFF_FFFF);
            chk("t4_hold_src", {31'd0, out_src}, 32'd0);
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        push(1'b1, 32'hFFFF_0000);
        chk_rdy("t4go", 1'b0, 1'b1);
        step();
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        push(1'b0, 32'h8000_0000);
        chk_rdy("t4a", 1'b1, 1'b0);
        step();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        step(); step();
        chk("t4_drained_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_drained_data", out_data, 32'h8000_0000);

        // 5: reset while a result is held, then A wins the first tie
        out_ready = 1'b0;
        set_a(1'b1, 32'h5555_5555, 5'd1, 1'b0);
        step();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        chk("t5_loaded", {31'd0, out_valid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_async_data", out_data, 32'h0);
        step(); step();
        reset = 1'b1;
        out_ready = 1'b1;
        set_a(1'b1, 32'h0000_0003, 5'd2, 1'b0);
        set_b(1'b1, 32'hC000_0000, 5'd1, 1'b1);
        push(1'b0, 32'h0000_000C);
        chk_rdy("t5tie", 1'b1, 1'b0);
        step();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        push(1'b1, 32'hE000_0000);
        chk_rdy("t5b", 1'b0, 1'b1);
        step();
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        step(); step();
        chk("t5_queue_empty", exp_q.size(), 32'd0);

`ifdef SHIFT_GRANT_CNT_EN
        // 6: saturating handshake counters
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_a_cnt_rst", {16'd0, a_grant_cnt}, 32'd0);
        chk("t6_b_cnt_rst", {16'd0, b_grant_cnt}, 32'd0);
        set_a(1'b1, 32'h0000_0001, 5'd0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            push(1'b0, 32'h0000_0001);
            step();
        end
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        chk("t6_a_cnt_sat", {16'd0, a_grant_cnt}, 32'h0000_FFFF);
        chk("t6_b_cnt", {16'd0, b_grant_cnt}, 32'd0);
`endif

        step(); step(); step();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one pair of combinational 32-bit barrel shifters (logical-left and arithmetic-right) between two requesters, port A and port B. Port A is the ALU shift path; port B is the multdiv/immediate-adjust path. The block does round-robin arbitration and valid/ready handshakes on both sides. It registers the result in a single-entry output stage, so latency is 1 cycle and throughput is 1 shift per cycle.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported.
SHAMT_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
a_valid  in  1  port A request valid.
a_ready  out  1  port A request accepted this cycle.
a_data  in  32  port A operand.
a_shamt  in  5  port A shift amount.
a_op  in  1  port A op: 0 = sll, 1 = sra.
b_valid, b_ready, b_data, b_shamt, b_op: same as port A, for port B.
out_valid  out  1  result register holds a valid result.
out_ready  in  1  consumer accepts the result.
out_data  out  32  shifted result.
out_src  out  1  origin of the result: 0 = A, 1 = B.
busy  out  1  equals out_valid.

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, out_data=0, out_src=0, last_grant=1 (so A wins the first tie). a_ready and b_ready evaluate to 0 unless a request is present.
- free = !out_valid | out_ready. The output stage can load this cycle only when free is 1.
- Grant (combinational):
  - If only one valid is high, that port is granted.
  - If both are high, the port != last_grant is granted.
  - If neither is high, there is no grant.
- x_ready = grant_x & free. Ready may depend on the other port's valid. A requester's valid must never depend on its own ready.
- Handshake on port x completes when x_valid & x_ready. At the next edge:
  - out_data = shift(x_data, x_shamt, x_op)
  - out_src = x
  - out_valid = 1
  - last_grant = x
- If out_valid & out_ready and no request is accepted: out_valid goes to 0 at the next edge. out_data and out_src hold their values.
- Same-cycle drain and accept is allowed: the back-to-back result is loaded with no bubble.
- Backpressure (out_valid & !out_ready): out_data and out_src stay stable; a_ready = b_ready = 0; last_grant is unchanged.
- Requester rule: once x_valid is raised, x_data, x_shamt and x_op are held until the handshake completes.
- Arithmetic:
  - sll fills zeros.
  - sra replicates in[31].
  - shamt 0 passes the operand through unchanged.
  - shamt 31 with sra yields all sign bits.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with drain, or while stalled.
  - FULL -> EMPTY on drain with no accept.
- Reset mid-operation: the held result is discarded with no output pulse. Arbitration restarts with A preferred.

Optional Feature:
SHIFT_GRANT_CNT_EN:
- When defined, adds outputs a_grant_cnt[15:0] and b_grant_cnt[15:0].
- Each counter increments on its port's handshake and saturates at 16'hFFFF.
- Both counters reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - op encodings SHIFT_OP_SLL=1'b0 and SHIFT_OP_SRA=1'b1
  - source encodings SRC_A=1'b0 and SRC_B=1'b1
  - DATA_W and SHAMT_W defaults
- One natural sub-module: shift_rr_arb. It takes the two valids, last_grant and free, and produces grant_a, grant_b, a_ready and b_ready.
- The existing sll and sra shifters are instantiated directly, and the result is selected by the granted op.

Test Plan:
1. After reset, A only: a_data=32'h80000000, a_shamt=4, a_op=sra, out_ready=1 -> next cycle out_valid=1, out_data=32'hF8000000, out_src=0.
2. B only: b_data=32'h00000001, b_shamt=31, b_op=sll -> out_data=32'h80000000, out_src=1; shamt 0 with 32'h12345678 -> 32'h12345678.
3. A and B both valid for 4 cycles, out_ready=1 -> grants A,B,A,B; out_src sequence 0,1,0,1 with no bubbles.
4. out_ready=0 for 3 cycles while FULL and both requesting -> a_ready=b_ready=0 and out_data stable; out_ready=1 -> drain and new accept occur in the same cycle.
5. Reset low while out_valid=1 -> out_valid=0 immediately (asynchronous); after release, a simultaneous A/B request grants A first.
6. SHIFT_GRANT_CNT_EN defined, 70000 accepts on A -> a_grant_cnt=16'hFFFF (saturated), b_grant_cnt=0.
